// File: rtl/jtgng_ps2_keymap.sv
// +--------------------------------------------------------------------+
// | jtgng_ps2_keymap: PS/2 receiver + set-2 scan-code to key decoder    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module jtgng_ps2_keymap #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 24000
) (
  input  logic       clk_rgb,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [9:0] key_joy1,
  output logic [9:0] key_joy2,
  output logic [1:0] key_start,
  output logic [1:0] key_coin,
  output logic       key_reset,
  output logic       key_pause,
  output logic       frame_err
);

  localparam int c_FW = $clog2(FILTER + 1);
  localparam int c_WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

  logic [1:0]      r_clk_sync, r_dat_sync;
  logic            r_clk_filt;
  logic [c_FW-1:0] r_filt_cnt;
  logic            w_fall, w_dat, w_timeout;

  state_t          r_st, w_st_nxt;
  logic [2:0]      r_bitcnt;
  logic [7:0]      r_shift;
  logic            r_par;
  logic [c_WW-1:0] r_wd;
  logic            r_byte_valid, w_valid_nxt, w_err_nxt;

  logic            r_ext, r_brk;
  logic [2:0]      r_skip;
  logic [19:0]     r_keys, w_mask;

  assign w_dat     = r_dat_sync[1];
  // Strobe on the sample that completes FILTER consecutive lows
  assign w_fall    = r_clk_filt && !r_clk_sync[1] && (r_filt_cnt == c_FW'(FILTER - 1));
  assign w_timeout = (r_st != ST_IDLE) && !w_fall && (r_wd == c_WW'(TIMEOUT - 1));

  always_ff @(posedge clk_rgb) begin
    if (rst) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_clk_filt <= 1'b1;
      r_filt_cnt <= '0;
    end else begin
      r_clk_sync <= {r_clk_sync[0], ps2_clk};
      r_dat_sync <= {r_dat_sync[0], ps2_data};
      if (r_clk_sync[1] == r_clk_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == c_FW'(FILTER - 1)) begin
        r_clk_filt <= r_clk_sync[1];
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_st_nxt    = r_st;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    if (w_timeout) begin
      w_st_nxt  = ST_IDLE;
      w_err_nxt = 1'b1;
    end else if (w_fall) begin
      case (r_st)
        ST_IDLE:   if (w_dat) w_err_nxt = 1'b1; else w_st_nxt = ST_DATA;
        ST_DATA:   if (r_bitcnt == 3'd7) w_st_nxt = ST_PARITY;
        ST_PARITY: w_st_nxt = ST_STOP;
        default: begin
          w_st_nxt = ST_IDLE;
          if (w_dat && (^{r_shift, r_par})) w_valid_nxt = 1'b1;
          else                              w_err_nxt   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_rgb) begin
    if (rst) begin
      r_st         <= ST_IDLE;
      r_bitcnt     <= '0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_wd         <= '0;
      r_byte_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      r_st         <= w_st_nxt;
      r_byte_valid <= w_valid_nxt;
      frame_err    <= w_err_nxt;
      if (r_st == ST_IDLE || w_fall || w_timeout) r_wd <= '0;
      else                                          r_wd <= r_wd + 1'b1;
      if (w_fall && r_st == ST_IDLE) r_bitcnt <= '0;
      if (w_fall && r_st == ST_DATA) begin
        r_shift  <= {w_dat, r_shift[7:1]};
        r_bitcnt <= r_bitcnt + 1'b1;
      end
      if (w_fall && r_st == ST_PARITY) r_par <= w_dat;
    end
  end

  // Bit order: joy1[6:0], joy2[6:0], start[1:0], coin[1:0], pause, reset
  always_comb begin
    w_mask = '0;
    case ({r_ext, r_shift})
      9'h174: w_mask[0]  = 1'b1;
      9'h16B: w_mask[1]  = 1'b1;
      9'h172: w_mask[2]  = 1'b1;
      9'h175: w_mask[3]  = 1'b1;
      9'h014: w_mask[4]  = 1'b1;
      9'h011: w_mask[5]  = 1'b1;
      9'h029: w_mask[6]  = 1'b1;
      9'h034: w_mask[7]  = 1'b1;
      9'h023: w_mask[8]  = 1'b1;
      9'h02B: w_mask[9]  = 1'b1;
      9'h02D: w_mask[10] = 1'b1;
      9'h01C: w_mask[11] = 1'b1;
      9'h01B: w_mask[12] = 1'b1;
      9'h015: w_mask[13] = 1'b1;
      9'h016: w_mask[14] = 1'b1;
      9'h01E: w_mask[15] = 1'b1;
      9'h02E: w_mask[16] = 1'b1;
      9'h036: w_mask[17] = 1'b1;
      9'h04D: w_mask[18] = 1'b1;
      9'h004: w_mask[19] = 1'b1;
      default: w_mask = '0;
    endcase
  end

  // Key states survive frame errors; only the prefix state is discarded
  always_ff @(posedge clk_rgb) begin
    if (rst) begin
      r_ext  <= 1'b0;
      r_brk  <= 1'b0;
      r_skip <= '0;
      r_keys <= '0;
    end else if (frame_err) begin
      r_ext  <= 1'b0;
      r_brk  <= 1'b0;
      r_skip <= '0;
    end else if (r_byte_valid) begin
      if (r_skip != 3'd0)        r_skip <= r_skip - 1'b1;
      else if (r_shift == 8'hE0) r_ext  <= 1'b1;
      else if (r_shift == 8'hF0) r_brk  <= 1'b1;
      else if (r_shift == 8'hE1) r_skip <= 3'd7;
      else begin
        r_keys <= r_brk ? (r_keys & ~w_mask) : (r_keys | w_mask);
        r_ext  <= 1'b0;
        r_brk  <= 1'b0;
      end
    end
  end

  assign key_joy1  = {3'b000, r_keys[6:0]};
  assign key_joy2  = {3'b000, r_keys[13:7]};
  assign key_start = r_keys[15:14];
  assign key_coin  = r_keys[17:16];
  assign key_pause = r_keys[18];
  assign key_reset = r_keys[19];

endmodule

`default_nettype wire
